// File: rtl/bar_chart_sequencer.sv
// Bar chart frame sequencer: holds a small table of bar heights and, on
// request, steps a column plotter through an erase pass and a draw pass for
// every bar, left to right, then pulses frame_done.
module bar_chart_sequencer #(
   parameter int          NUM_BARS   = 8,
   parameter int          BASE_X     = 20,
   parameter int          BAR_PITCH  = 10,
   parameter int          BASE_Y     = 220,
   parameter int          MAX_HEIGHT = 200,
   parameter logic [2:0]  BAR_COLOUR = 3'b010,
   parameter logic [2:0]  BG_COLOUR  = 3'b000
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       start,
   input  logic       bar_we,
   input  logic [2:0] bar_wr_idx,
   input  logic [7:0] bar_wr_height,
   input  logic       draw_done,
   output logic       draw_clr_n,
   output logic       draw_enable,
   output logic [8:0] draw_x,
   output logic [7:0] draw_y,
   output logic [7:0] draw_height,
   output logic [2:0] colour,
   output logic       plot,
   output logic       busy,
   output logic       frame_done
);

   typedef enum logic [2:0] {IDLE, CLR_E, ERASE, CLR_D, DRAW, FIN} state_t;

   state_t     state;
   state_t     state_next;
   logic [2:0] idx;
   logic [7:0] heights [0:7];
   logic [7:0] work_height;
   logic       clr_hold;
   logic [7:0] wr_sat;
   logic       last_bar;

   assign wr_sat   = (bar_wr_height > 8'(MAX_HEIGHT)) ? 8'(MAX_HEIGHT) : bar_wr_height;
   assign last_bar = (idx == 3'(NUM_BARS - 1));
   assign plot     = draw_enable & ~draw_done;

   // State register
   always_ff @(posedge clk) begin
      if (!resetn) state <= IDLE;
      else         state <= state_next;
   end

   // Bar index, latched draw height, and the one-cycle plotter clear after reset
   always_ff @(posedge clk) begin
      if (!resetn) begin
         idx         <= '0;
         work_height <= '0;
         clr_hold    <= 1'b1;
      end else begin
         clr_hold <= 1'b0;
         if (state == IDLE && start)
            idx <= '0;
         else if (state == DRAW && draw_done && !last_bar)
            idx <= idx + 3'd1;
         // Latching here keeps draw_height stable while the table is rewritten mid-pass
         if (state == CLR_D)
            work_height <= heights[idx];
      end
   end

   // Height table with saturating writes; indices beyond NUM_BARS are dropped
   always_ff @(posedge clk) begin
      if (!resetn) begin
         for (int unsigned i = 0; i < 8; i++) heights[i] <= '0;
      end else if (bar_we) begin
         for (int unsigned i = 0; i < NUM_BARS; i++)
            if (bar_wr_idx == 3'(i)) heights[i] <= wr_sat;
      end
   end

   // Next-state logic and plotter/framebuffer controls
   always_comb begin
      state_next  = state;
      draw_clr_n  = 1'b1;
      draw_enable = 1'b0;
      draw_height = '0;
      colour      = BG_COLOUR;
      busy        = 1'b1;
      frame_done  = 1'b0;
      draw_x      = 9'(BASE_X + int'(idx) * BAR_PITCH);
      draw_y      = 8'(BASE_Y);
      case (state)
         IDLE: begin
            busy       = 1'b0;
            draw_x     = '0;
            draw_y     = '0;
            draw_clr_n = ~clr_hold;
            if (start) state_next = CLR_E;
         end
         CLR_E: begin
            draw_clr_n = 1'b0;
            state_next = ERASE;
         end
         ERASE: begin
            draw_enable = 1'b1;
            draw_height = 8'(MAX_HEIGHT);
            if (draw_done) state_next = CLR_D;
         end
         CLR_D: begin
            draw_clr_n = 1'b0;
            state_next = DRAW;
         end
         DRAW: begin
            draw_enable = 1'b1;
            draw_height = work_height;
            colour      = BAR_COLOUR;
            if (draw_done) state_next = last_bar ? FIN : CLR_E;
         end
         FIN: begin
            frame_done = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

endmodule

// File: tb/tb_bar_chart_sequencer.sv
// Self-checking bench for bar_chart_sequencer: a column plotter model answers
// the draw handshake, expected passes are queued when a frame is started and
// popped as each pass begins.
module tb_bar_chart_sequencer;

   logic       clk = 1'b0;
   logic       resetn, start, bar_we, draw_done;
   logic [2:0] bar_wr_idx;
   logic [7:0] bar_wr_height;
   logic       draw_clr_n, draw_enable, plot, busy, frame_done;
   logic [8:0] draw_x;
   logic [7:0] draw_y, draw_height;
   logic [2:0] colour;

   localparam int BAR_C = 2;
   localparam int BG_C  = 0;

   bar_chart_sequencer #(
      .NUM_BARS(8), .BASE_X(20), .BAR_PITCH(10), .BASE_Y(220), .MAX_HEIGHT(200),
      .BAR_COLOUR(3'b010), .BG_COLOUR(3'b000)
   ) dut (
      .clk(clk), .resetn(resetn), .start(start), .bar_we(bar_we),
      .bar_wr_idx(bar_wr_idx), .bar_wr_height(bar_wr_height), .draw_done(draw_done),
      .draw_clr_n(draw_clr_n), .draw_enable(draw_enable), .draw_x(draw_x),
      .draw_y(draw_y), .draw_height(draw_height), .colour(colour), .plot(plot),
      .busy(busy), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   typedef struct { int x; int h; int col; } pass_t;
   typedef struct { logic [2:0] idx; logic [7:0] h; logic [7:0] exp; } vec_t;

   pass_t      q[$];
   vec_t       vecs[8];
   int         checks = 0;
   int         failures = 0;
   int         frames = 0;
   int         passes = 0;
   int         model[8];
   bit         hold_mode = 1'b0;
   int         lat = 1;
   int         pl_cnt = 0;
   bit         prev_en = 1'b0;
   bit         fd_prev = 1'b0;
   int         clr_run = 0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Column plotter model: done rises after a random latency, stays high until cleared
   initial begin
      draw_done = 1'b0;
      forever begin
         @(negedge clk);
         if (!draw_clr_n) begin
            pl_cnt    = 0;
            draw_done = hold_mode;
            lat       = $urandom_range(1, 4);
         end else if (hold_mode) begin
            draw_done = 1'b1;
         end else if (draw_enable && !draw_done) begin
            pl_cnt++;
            if (pl_cnt >= lat) draw_done = 1'b1;
         end
      end
   end

   // Monitor: pass scoreboard plus per-cycle protocol checks
   initial begin
      pass_t e;
      forever begin
         @(posedge clk); #1;
         if (fd_prev) check("busy_after_frame_done", busy, 0);
         fd_prev = frame_done;
         if (frame_done) begin
            frames++;
            check("busy_in_fin", busy, 1);
            check("enable_in_fin", draw_enable, 0);
         end
         if (!draw_enable)   check("plot_when_disabled", plot, 0);
         else if (draw_done) check("plot_when_done", plot, 0);
         else                check("plot_while_drawing", plot, 1);
         if (busy && !draw_clr_n) begin
            clr_run++;
            check("clr_single_cycle", clr_run, 1);
            check("enable_in_clr", draw_enable, 0);
         end else begin
            clr_run = 0;
         end
         if (draw_enable && !prev_en) begin
            passes++;
            if (q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_pass: got x=%0d h=%0d with nothing expected", draw_x, draw_height);
            end else begin
               e = q.pop_front();
               check("pass_x", int'(draw_x), e.x);
               check("pass_y", int'(draw_y), 220);
               check("pass_height", int'(draw_height), e.h);
               check("pass_colour", int'(colour), e.col);
            end
         end
         prev_en = draw_enable;
      end
   end

   task automatic write_h(input logic [2:0] i, input logic [7:0] h, input int exp);
      @(negedge clk);
      bar_we = 1'b1; bar_wr_idx = i; bar_wr_height = h;
      model[i] = exp;
      @(negedge clk);
      bar_we = 1'b0;
   endtask

   task automatic push_frame();
      for (int i = 0; i < 8; i++) begin
         pass_t p;
         p.x = 20 + 10 * i; p.h = 200; p.col = BG_C;
         q.push_back(p);
         p.h = model[i]; p.col = BAR_C;
         q.push_back(p);
      end
   endtask

   task automatic pulse_start();
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
   endtask

   task automatic wait_frame_done(input string name);
      int n = 0;
      do begin
         @(posedge clk); #1; n++;
      end while (!frame_done && n < 2000);
      check(name, int'(frame_done), 1);
   endtask

   task automatic wait_bar(input int col, input int x, input string name);
      int n = 0;
      while (!(draw_enable && int'(colour) == col && int'(draw_x) == x) && n < 2000) begin
         @(posedge clk); #1; n++;
      end
      check(name, int'(draw_x), x);
   endtask

   task automatic run_frame(input string name);
      push_frame();
      pulse_start();
      wait_frame_done(name);
      @(posedge clk); #1;
      check({name, "_queue_empty"}, q.size(), 0);
   endtask

   initial begin
      int fr;
      vecs[0] = '{3'd3, 8'd250, 8'd200};
      vecs[1] = '{3'd0, 8'd0,   8'd0};
      vecs[2] = '{3'd1, 8'd200, 8'd200};
      vecs[3] = '{3'd2, 8'd201, 8'd200};
      vecs[4] = '{3'd4, 8'd199, 8'd199};
      vecs[5] = '{3'd5, 8'd255, 8'd200};
      vecs[6] = '{3'd6, 8'd1,   8'd1};
      vecs[7] = '{3'd7, 8'd128, 8'd128};

      resetn = 1'b0; start = 1'b0; bar_we = 1'b0; bar_wr_idx = '0; bar_wr_height = '0;
      for (int i = 0; i < 8; i++) model[i] = 0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_busy", busy, 0);
      check("rst_frame_done", frame_done, 0);
      check("rst_enable", draw_enable, 0);
      check("rst_clr_n", draw_clr_n, 0);
      check("rst_plot", plot, 0);
      check("rst_colour", int'(colour), BG_C);
      @(negedge clk); resetn = 1'b1;
      @(posedge clk); #1;
      check("clr_n_release", draw_clr_n, 1);
      check("idle_busy", busy, 0);

      // Ramp of heights, start held high for the whole frame
      for (int i = 0; i < 8; i++) write_h(3'(i), 8'(10 * (i + 1)), 10 * (i + 1));
      push_frame();
      @(negedge clk); start = 1'b1;
      wait_frame_done("frame1_done");
      @(negedge clk); start = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      check("no_restart_busy", busy, 0);
      check("frames_after_held_start", frames, 1);
      check("passes_frame1", passes, 16);
      check("frame1_queue_empty", q.size(), 0);

      // Table-driven writes including saturation
      foreach (vecs[k]) write_h(vecs[k].idx, vecs[k].h, int'(vecs[k].exp));
      run_frame("frame_vectors");
      check("frames_after_vectors", frames, 2);

      // Rewrite bar 2 while its draw pass is running
      push_frame();
      pulse_start();
      wait_bar(BAR_C, 40, "reach_draw_bar2");
      write_h(3'd2, 8'd99, 99);
      wait_frame_done("frame_midwrite_done");
      @(posedge clk); #1;
      check("midwrite_queue_empty", q.size(), 0);
      run_frame("frame_after_midwrite");

      // Reset in the middle of bar 4's erase pass
      push_frame();
      pulse_start();
      wait_bar(BG_C, 60, "reach_erase_bar4");
      fr = frames;
      @(negedge clk); resetn = 1'b0;
      @(posedge clk); #1;
      check("midrst_busy", busy, 0);
      check("midrst_enable", draw_enable, 0);
      check("midrst_frame_done", frame_done, 0);
      check("midrst_clr_n", draw_clr_n, 0);
      @(negedge clk); resetn = 1'b1;
      q.delete();
      for (int i = 0; i < 8; i++) model[i] = 0;
      repeat (5) @(posedge clk);
      #1;
      check("midrst_no_frame_done", frames, fr);

      // Cleared table, every height 0, done held high across the clear cycles
      hold_mode = 1'b1;
      run_frame("frame_hold_done");
      hold_mode = 1'b0;
      check("frames_after_hold", frames, fr + 1);

      write_h(3'd5, 8'd77, 77);
      run_frame("frame_final");
      check("frames_final", frames, fr + 2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
